// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the 9-bit four-instruction processor and
// its program-feed front end.
//   WORD_W  - instruction/data word width
//   OP_W    - opcode field width (word bits [8:6])
//   OP_*    - opcode values; any opcode with the MSB set behaves as HALT
package proc_pkg;

    localparam int unsigned WORD_W = 9;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_MV   = 3'b000;
    localparam logic [OP_W-1:0] OP_MVI  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OP_W-1:0] OP_HALT = 3'b111;

    // Opcode field of an instruction word
    function automatic logic [OP_W-1:0] opOf(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: OP_W];
    endfunction

    // Opcodes 100..111 all stop the sequencer
    function automatic logic isHaltClass(input logic [OP_W-1:0] op);
        return op[OP_W-1];
    endfunction

endpackage

// File: rtl/prog_mem.sv
// prog_mem: DEPTH x WORD_W program storage, no reset.
//   Clock          - write clock
//   We             - synchronous write enable
//   WrAddr/WrData  - write port
//   RdAddr         - combinational read address
//   RdDataA        - mem[RdAddr]
//   RdDataB        - mem[RdAddr+1], wrapping at DEPTH
module prog_mem
    import proc_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic              Clock,
    input  logic              We,
    input  logic [AW-1:0]     WrAddr,
    input  logic [WORD_W-1:0] WrData,
    input  logic [AW-1:0]     RdAddr,
    output logic [WORD_W-1:0] RdDataA,
    output logic [WORD_W-1:0] RdDataB
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rdAddrB;

    always_ff @(posedge Clock) begin
        if (We) begin
            mem[WrAddr] <= WrData;
        end
    end

    // DEPTH is a power of two, so AW-bit addition wraps naturally
    assign rdAddrB = AW'(RdAddr + AW'(1));
    assign RdDataA = mem[RdAddr];
    assign RdDataB = mem[rdAddrB];

endmodule

// File: rtl/proc_sequencer.sv
// proc_sequencer: feeds a loadable program to the 9-bit processor, one
// instruction at a time, supplying the MVI immediate and waiting for Done.
//   Clock, Reset        - clock, synchronous active-high reset
//   Start               - run from address 0 (only when idle or halted)
//   ProgWe/Addr/Data    - program load port (ignored while Busy)
//   Done                - processor completion flag
//   DIN, Run            - word and issue strobe to the processor
//   Busy, Halted, Error - status
//   Pc, InstrCount      - current/next address, completed instruction count
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned WDOG  = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              ProgWe,
    input  logic [AW-1:0]     ProgAddr,
    input  logic [WORD_W-1:0] ProgData,
    input  logic              Done,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [AW-1:0]     Pc,
    output logic [15:0]       InstrCount
);

    localparam int unsigned CW = $clog2(WDOG + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, IMM, WAIT, HALT} seqState_t;

    seqState_t         state, stateNext;
    logic [CW-1:0]     wdCnt, wdCntNext;
    logic              curMvi, curMviNext;
    logic [AW-1:0]     pcNext;
    logic [WORD_W-1:0] dinNext;
    logic              runNext, busyNext, haltedNext, errorNext;
    logic [15:0]       countNext;

    logic [AW:0]       advPc;
    logic              acceptDone, startOk, issueReq, memWe;
    logic [AW-1:0]     rdAddr;
    logic [WORD_W-1:0] rdDataA, rdDataB;
    logic [OP_W-1:0]   rdOp;

    assign memWe = ProgWe && (state == IDLE || state == HALT);

    prog_mem #(.DEPTH(DEPTH), .AW(AW)) uMem (
        .Clock   (Clock),
        .We      (memWe),
        .WrAddr  (ProgAddr),
        .WrData  (ProgData),
        .RdAddr  (rdAddr),
        .RdDataA (rdDataA),
        .RdDataB (rdDataB)
    );

    // Read address is the instruction about to be issued, so the issue
    // decision is made on the edge that enters ISSUE and Run can be registered
    always_comb begin
        advPc      = {1'b0, Pc} + (curMvi ? (AW+1)'(2) : (AW+1)'(1));
        acceptDone = (state == WAIT) && Done && (wdCnt >= CW'(2));
        startOk    = Start && (state == IDLE || state == HALT);
        if (startOk) begin
            rdAddr = '0;
        end else if (acceptDone) begin
            rdAddr = advPc[AW-1:0];
        end else begin
            rdAddr = Pc;
        end
    end

    assign rdOp = opOf(rdDataA);

    // Next-state and registered-output values
    always_comb begin
        stateNext  = state;
        wdCntNext  = wdCnt;
        curMviNext = curMvi;
        pcNext     = Pc;
        dinNext    = '0;
        runNext    = 1'b0;
        haltedNext = Halted;
        errorNext  = Error;
        countNext  = InstrCount;
        issueReq   = 1'b0;

        case (state)
            IDLE, HALT: begin
                if (startOk) begin
                    countNext  = '0;
                    haltedNext = 1'b0;
                    errorNext  = 1'b0;
                    issueReq   = 1'b1;
                end
            end
            ISSUE: begin
                // wdCnt counts cycles since the Run cycle
                wdCntNext = CW'(1);
                if (curMvi) begin
                    stateNext = IMM;
                    dinNext   = rdDataB;
                end else begin
                    stateNext = WAIT;
                end
            end
            IMM: begin
                wdCntNext = CW'(wdCnt + CW'(1));
                stateNext = WAIT;
            end
            WAIT: begin
                wdCntNext = CW'(wdCnt + CW'(1));
                if (acceptDone) begin
                    if (InstrCount != 16'hFFFF) begin
                        countNext = InstrCount + 16'd1;
                    end
                    if (advPc[AW]) begin
                        pcNext     = advPc[AW-1:0];
                        haltedNext = 1'b1;
                        stateNext  = HALT;
                    end else begin
                        issueReq = 1'b1;
                    end
                end else if (wdCnt == CW'(WDOG - 1)) begin
                    errorNext  = 1'b1;
                    haltedNext = 1'b1;
                    stateNext  = HALT;
                end
            end
            default: stateNext = IDLE;
        endcase

        // Issue check on the word at rdAddr: halt, MVI-at-end error, or issue
        if (issueReq) begin
            pcNext = rdAddr;
            if (isHaltClass(rdOp)) begin
                haltedNext = 1'b1;
                stateNext  = HALT;
            end else if (rdOp == OP_MVI && rdAddr == AW'(DEPTH - 1)) begin
                errorNext  = 1'b1;
                haltedNext = 1'b1;
                stateNext  = HALT;
            end else begin
                stateNext  = ISSUE;
                runNext    = 1'b1;
                dinNext    = rdDataA;
                curMviNext = (rdOp == OP_MVI);
            end
        end

        busyNext = (stateNext == ISSUE) || (stateNext == IMM) || (stateNext == WAIT);
    end

    // State and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            wdCnt      <= '0;
            curMvi     <= 1'b0;
            Pc         <= '0;
            DIN        <= '0;
            Run        <= 1'b0;
            Busy       <= 1'b0;
            Halted     <= 1'b0;
            Error      <= 1'b0;
            InstrCount <= '0;
        end else begin
            state      <= stateNext;
            wdCnt      <= wdCntNext;
            curMvi     <= curMviNext;
            Pc         <= pcNext;
            DIN        <= dinNext;
            Run        <= runNext;
            Busy       <= busyNext;
            Halted     <= haltedNext;
            Error      <= errorNext;
            InstrCount <= countNext;
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: directed test of proc_sequencer against a small
// reference-processor model (Done two cycles after Run for MV/MVI, four for
// ADD/SUB).
module tb_proc_sequencer;
    import proc_pkg::*;

    logic        Clock, Reset, Start, ProgWe, Done;
    logic [4:0]  ProgAddr;
    logic [8:0]  ProgData;
    logic [8:0]  DIN;
    logic        Run, Busy, Halted, Error;
    logic [4:0]  Pc;
    logic [15:0] InstrCount;

    int total = 0;
    int bad   = 0;
    int runCount = 0;
    bit modelOn  = 1'b1;
    int rc0;

    proc_sequencer #(.DEPTH(32), .AW(5), .WDOG(8)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .ProgWe     (ProgWe),
        .ProgAddr   (ProgAddr),
        .ProgData   (ProgData),
        .Done       (Done),
        .DIN        (DIN),
        .Run        (Run),
        .Busy       (Busy),
        .Halted     (Halted),
        .Error      (Error),
        .Pc         (Pc),
        .InstrCount (InstrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference processor: counts Run pulses, raises Done for one cycle
    initial begin
        int k;
        int lat;
        k   = 0;
        lat = 0;
        Done = 1'b0;
        forever begin
            @(negedge Clock);
            if (Run === 1'b1) begin
                runCount++;
                lat  = (opOf(DIN) == OP_ADD || opOf(DIN) == OP_SUB) ? 4 : 2;
                k    = 0;
                Done = 1'b0;
            end else if (k < lat) begin
                k++;
                Done = modelOn && (k == lat);
            end else begin
                Done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic loadWord(input int a, input int d);
        ProgWe   = 1'b1;
        ProgAddr = 5'(a);
        ProgData = 9'(d);
        @(negedge Clock);
        ProgWe   = 1'b0;
    endtask

    // Returns in the middle of the first Run cycle (c0)
    task automatic pulseStart();
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic waitHalt(input int maxCyc);
        int n = 0;
        while (Halted !== 1'b1 && n < maxCyc) begin
            @(negedge Clock);
            n++;
        end
        check("haltWait", 32'(Halted), 32'd1);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; ProgWe = 1'b0; ProgAddr = '0; ProgData = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        check("rstRun",    32'(Run),        32'd0);
        check("rstBusy",   32'(Busy),       32'd0);
        check("rstHalted", 32'(Halted),     32'd0);
        check("rstDin",    32'(DIN),        32'd0);
        check("rstCount",  32'(InstrCount), 32'd0);

        // MVI r0,#5 ; MV r1,r0 ; HALT
        loadWord(0, 9'b001000000);
        loadWord(1, 9'b000000101);
        loadWord(2, 9'b000001000);
        loadWord(3, 9'b111000000);
        pulseStart();
        check("t1Run0",  32'(Run),  32'd1);
        check("t1Din0",  32'(DIN),  32'h040);
        check("t1Busy0", 32'(Busy), 32'd1);
        @(negedge Clock);
        check("t1Imm",   32'(DIN),  32'h005);
        check("t1RunC1", 32'(Run),  32'd0);
        repeat (2) @(negedge Clock);
        check("t1Run1",  32'(Run),        32'd1);
        check("t1Din1",  32'(DIN),        32'h008);
        check("t1Pc1",   32'(Pc),         32'd2);
        check("t1Cnt1",  32'(InstrCount), 32'd1);
        repeat (3) @(negedge Clock);
        check("t1Halt",  32'(Halted),     32'd1);
        check("t1Pc",    32'(Pc),         32'd3);
        check("t1Cnt",   32'(InstrCount), 32'd2);
        check("t1Busy",  32'(Busy),       32'd0);
        check("t1Err",   32'(Error),      32'd0);

        // ADD then HALT: Done accepted in c4, Halted visible in c5
        loadWord(0, 9'b010000001);
        loadWord(1, 9'b111000000);
        pulseStart();
        check("t2Run0",   32'(Run),    32'd1);
        check("t2Din0",   32'(DIN),    32'h081);
        check("t2Clr",    32'(Halted), 32'd0);
        repeat (4) @(negedge Clock);
        check("t2RunC4",  32'(Run),    32'd0);
        check("t2HaltC4", 32'(Halted), 32'd0);
        @(negedge Clock);
        check("t2Halt",   32'(Halted),     32'd1);
        check("t2Cnt",    32'(InstrCount), 32'd1);
        check("t2Pc",     32'(Pc),         32'd1);
        check("t2Run",    32'(Run),        32'd0);

        // Watchdog: no Done, Error exactly 8 cycles after Run
        modelOn = 1'b0;
        loadWord(0, 9'b000001000);
        pulseStart();
        check("t3Run0",  32'(Run),   32'd1);
        repeat (7) @(negedge Clock);
        check("t3ErrC7", 32'(Error), 32'd0);
        check("t3BusyC7", 32'(Busy), 32'd1);
        @(negedge Clock);
        check("t3Err",   32'(Error),      32'd1);
        check("t3Halt",  32'(Halted),     32'd1);
        check("t3Busy",  32'(Busy),       32'd0);
        check("t3Cnt",   32'(InstrCount), 32'd0);
        modelOn = 1'b1;

        // 31 MV words then MVI in the last word
        for (int i = 0; i < 31; i++) loadWord(i, 9'b000001000);
        loadWord(31, 9'b001000000);
        rc0 = runCount;
        pulseStart();
        waitHalt(300);
        check("t4Err",  32'(Error),      32'd1);
        check("t4Cnt",  32'(InstrCount), 32'd31);
        check("t4Pc",   32'(Pc),         32'd31);
        check("t4Runs", 32'(runCount - rc0), 32'd31);

        // Full memory of MV words: wraps to Pc=0
        for (int i = 0; i < 32; i++) loadWord(i, 9'b000001000);
        rc0 = runCount;
        pulseStart();
        waitHalt(300);
        check("t5Err",  32'(Error),      32'd0);
        check("t5Cnt",  32'(InstrCount), 32'd32);
        check("t5Pc",   32'(Pc),         32'd0);
        check("t5Runs", 32'(runCount - rc0), 32'd32);

        // Reset during WAIT; write while Busy must be dropped
        loadWord(0, 9'b010000001);
        loadWord(1, 9'b111000000);
        rc0 = runCount;
        pulseStart();
        @(negedge Clock);
        check("t6Busy", 32'(Busy), 32'd1);
        ProgWe = 1'b1; ProgAddr = 5'd1; ProgData = 9'b000001000;
        @(negedge Clock);
        ProgWe = 1'b0;
        Reset  = 1'b1;
        @(negedge Clock);
        Reset  = 1'b0;
        check("t6Run",    32'(Run),        32'd0);
        check("t6Busy0",  32'(Busy),       32'd0);
        check("t6Halt",   32'(Halted),     32'd0);
        check("t6Err",    32'(Error),      32'd0);
        check("t6Pc",     32'(Pc),         32'd0);
        check("t6Cnt",    32'(InstrCount), 32'd0);
        check("t6Din",    32'(DIN),        32'd0);
        pulseStart();
        waitHalt(50);
        check("t6MemCnt", 32'(InstrCount), 32'd1);
        check("t6MemPc",  32'(Pc),         32'd1);
        check("t6Runs",   32'(runCount - rc0), 32'd2);

        // Reset beats Start
        Reset = 1'b1; Start = 1'b1;
        @(negedge Clock);
        Reset = 1'b0; Start = 1'b0;
        check("rsBusy", 32'(Busy), 32'd0);
        check("rsRun",  32'(Run),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
